// File: rtl/page_table_walker.sv
// Two-level page-table walker. Reads the root entry (VPN1) and, for a
// pointer PTE, the L0 entry (VPN0); returns the leaf PTE, its level and a
// fault flag to the TLB over a valid/ready handshake.
// Optional build macro: PTW_PTR_CACHE_EN adds a one-entry cache of the last
// root pointer so a walk with the same VPN1 skips the root read.
module page_table_walker #(
    parameter logic [31:0] ROOT_BASE = 32'h0000_0400,
    parameter int unsigned VA_W      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            walk_req_valid_i,
    output logic            walk_req_ready_o,
    input  logic [VA_W-1:0] walk_vaddr_i,
    output logic            walk_resp_valid_o,
    input  logic            walk_resp_ready_i,
    output logic [31:0]     walk_pte_o,
    output logic            walk_level_o,
    output logic            walk_fault_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [31:0]     mem_addr_o,
    input  logic            mem_resp_valid_i,
    output logic            mem_resp_ready_o,
    input  logic [31:0]     mem_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_RESP,
        S_L0_REQ,
        S_L0_RESP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Only the VPN fields of the request address are needed after acceptance.
    logic [9:0]  vpn1_q, vpn0_q;
    logic [31:0] base_q;
    logic [31:0] pte_q;
    logic        level_q;
    logic        fault_q;

    logic [9:0]  req_vpn1, req_vpn0;
    logic        unused_vaddr_low;

    assign req_vpn1         = walk_vaddr_i[VA_W-1 -: 10];
    assign req_vpn0         = walk_vaddr_i[VA_W-11 -: 10];
    assign unused_vaddr_low = ^walk_vaddr_i[VA_W-21:0];

    // PTE decode of the incoming memory word
    logic pte_v, pte_r, pte_w, pte_x;
    logic pte_fault, pte_ptr;

    assign pte_v     = mem_data_i[0];
    assign pte_r     = mem_data_i[1];
    assign pte_w     = mem_data_i[2];
    assign pte_x     = mem_data_i[3];
    assign pte_fault = !pte_v || (pte_w && !pte_r);
    assign pte_ptr   = !pte_fault && !pte_r && !pte_w && !pte_x;

    // Root-pointer cache lookup
    logic        cache_hit;
    logic [31:0] cache_base;

`ifdef PTW_PTR_CACHE_EN
    logic        cache_valid_q;
    logic [9:0]  cache_vpn1_q;
    logic [31:0] cache_base_q;

    assign cache_hit  = cache_valid_q && (cache_vpn1_q == req_vpn1);
    assign cache_base = cache_base_q;

    // Fill on every root pointer decode; leaves and faults never enter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_q <= 1'b0;
            cache_vpn1_q  <= '0;
            cache_base_q  <= '0;
        end else if (state_q == S_L1_RESP && mem_resp_valid_i && pte_ptr) begin
            cache_valid_q <= 1'b1;
            cache_vpn1_q  <= vpn1_q;
            cache_base_q  <= {mem_data_i[31:10], 10'b0};
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_base = '0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d           = state_q;
        walk_req_ready_o  = 1'b0;
        walk_resp_valid_o = 1'b0;
        mem_req_valid_o   = 1'b0;
        mem_addr_o        = '0;
        mem_resp_ready_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                walk_req_ready_o = 1'b1;
                if (walk_req_valid_i) begin
                    state_d = cache_hit ? S_L0_REQ : S_L1_REQ;
                end
            end
            S_L1_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = ROOT_BASE + {20'b0, vpn1_q, 2'b00};
                if (mem_req_ready_i) begin
                    state_d = S_L1_RESP;
                end
            end
            S_L1_RESP: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) begin
                    state_d = pte_ptr ? S_L0_REQ : S_DONE;
                end
            end
            S_L0_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = base_q + {20'b0, vpn0_q, 2'b00};
                if (mem_req_ready_i) begin
                    state_d = S_L0_RESP;
                end
            end
            S_L0_RESP: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                walk_resp_valid_o = 1'b1;
                if (walk_resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result outputs are only presented while the result is valid
    assign walk_pte_o   = (state_q == S_DONE) ? pte_q : '0;
    assign walk_level_o = (state_q == S_DONE) ? level_q : 1'b0;
    assign walk_fault_o = (state_q == S_DONE) ? fault_q : 1'b0;

    // Walk datapath: latch request VPNs, L0 base and the decoded result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vpn1_q  <= '0;
            vpn0_q  <= '0;
            base_q  <= '0;
            pte_q   <= '0;
            level_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (walk_req_valid_i) begin
                        vpn1_q <= req_vpn1;
                        vpn0_q <= req_vpn0;
                        if (cache_hit) begin
                            base_q <= cache_base;
                        end
                    end
                end
                S_L1_RESP: begin
                    if (mem_resp_valid_i) begin
                        base_q  <= {mem_data_i[31:10], 10'b0};
                        pte_q   <= pte_fault ? '0 : mem_data_i;
                        fault_q <= pte_fault;
                        level_q <= !pte_fault;
                    end
                end
                S_L0_RESP: begin
                    if (mem_resp_valid_i) begin
                        // A pointer found at level 0 has nowhere to go: fault
                        pte_q   <= (pte_fault || pte_ptr) ? '0 : mem_data_i;
                        fault_q <= pte_fault || pte_ptr;
                        level_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
